// File: rtl/picosoc_sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : picosoc_sdram_pkg
//  Description : Shared types and constants for the PicoSoC iomem to
//                SDRAM-controller bridge: the transaction state encoding,
//                the fill word returned on a read watchdog expiry, and the
//                default word-address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package picosoc_sdram_pkg;

    // Bridge transaction states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CMD  = 3'd1,
        RD_CMD  = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Word returned to the CPU when a read is abandoned by the watchdog
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    // Default word-address width (CPU byte address [25:2])
    localparam int DEFAULT_ADDR_W = 24;

endpackage : picosoc_sdram_pkg
`default_nettype wire

// File: rtl/picosoc_sdram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : picosoc_sdram_bridge
//  Description : Bridges the PicoSoC iomem port (valid/ready, byte strobes,
//                word address) to an Avalon-MM style SDRAM controller port
//                (active-low strobes, waitrequest, readdatavalid). One
//                transaction outstanding at a time; every output is a flop.
//  Build option: PICOSOC_SDRAM_TIMEOUT_EN - adds a read-data watchdog
//                (parameter TIMEOUT_CYCLES) and a sticky timeout_err output.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk            in   single clock, rising edge
//    reset          in   synchronous active-high reset
//    valid          in   iomem request valid, held until ready
//    wen[3:0]       in   byte write strobes, 0000 = read
//    addr[ADDR_W]   in   word address
//    wdata[31:0]    in   write data
//    rdata[31:0]    out  read data, valid while ready=1, held afterwards
//    ready          out  one-cycle completion pulse
//    az_addr        out  controller word address
//    az_be_n[3:0]   out  active-low byte enables
//    az_cs          out  chip select, high while a command is presented
//    az_data[31:0]  out  write data to controller
//    az_rd_n        out  active-low read request
//    az_wr_n        out  active-low write request
//    za_data[31:0]  in   read data from controller
//    za_valid       in   read data valid
//    za_waitrequest in   controller stall
//    timeout_err    out  sticky read-timeout flag (watchdog build only)
// ============================================================================
module picosoc_sdram_bridge
    import picosoc_sdram_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
`ifdef PICOSOC_SDRAM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1023
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] az_addr,
    output logic [3:0]        az_be_n,
    output logic              az_cs,
    output logic [31:0]       az_data,
    output logic              az_rd_n,
    output logic              az_wr_n,
    input  logic [31:0]       za_data,
    input  logic              za_valid,
    input  logic              za_waitrequest
`ifdef PICOSOC_SDRAM_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    state_t r_state;

`ifdef PICOSOC_SDRAM_TIMEOUT_EN
    localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Counts cycles spent in RD_WAIT; expiry fires on the last one
    logic [CNT_W-1:0] r_wd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            ready   <= 1'b0;
            rdata   <= 32'h0;
            az_rd_n <= 1'b1;
            az_wr_n <= 1'b1;
            az_cs   <= 1'b0;
            az_be_n <= 4'hF;
            az_addr <= '0;
            az_data <= 32'h0;
`ifdef PICOSOC_SDRAM_TIMEOUT_EN
            r_wd_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            // ready is a single-cycle pulse: only the transition into DONE sets it
            ready <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (valid && !ready) begin
                        az_addr <= addr;
                        az_data <= wdata;
                        az_cs   <= 1'b1;
                        if (wen != 4'b0000) begin
                            az_be_n <= ~wen;
                            az_wr_n <= 1'b0;
                            r_state <= WR_CMD;
                        end else begin
                            az_be_n <= 4'b0000;
                            az_rd_n <= 1'b0;
                            r_state <= RD_CMD;
                        end
                    end
                end

                // Command is held unchanged until the controller stops stalling
                WR_CMD: begin
                    if (!za_waitrequest) begin
                        az_wr_n <= 1'b1;
                        az_cs   <= 1'b0;
                        az_be_n <= 4'hF;
                        ready   <= 1'b1;
                        r_state <= DONE;
                    end
                end

                RD_CMD: begin
                    if (!za_waitrequest) begin
                        az_rd_n <= 1'b1;
                        az_cs   <= 1'b0;
                        az_be_n <= 4'hF;
                        r_state <= RD_WAIT;
`ifdef PICOSOC_SDRAM_TIMEOUT_EN
                        r_wd_cnt <= '0;
`endif
                    end
                end

                RD_WAIT: begin
                    if (za_valid) begin
                        rdata   <= za_data;
                        ready   <= 1'b1;
                        r_state <= DONE;
`ifdef PICOSOC_SDRAM_TIMEOUT_EN
                    end else if (r_wd_cnt == c_CNT_LAST) begin
                        rdata       <= TIMEOUT_DATA;
                        ready       <= 1'b1;
                        timeout_err <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
                    end
                end

                // ready is high during this cycle; return without relaunching
                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : picosoc_sdram_bridge
`default_nettype wire

// File: tb/tb_picosoc_sdram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_picosoc_sdram_bridge
//  Description : Directed self-checking bench for picosoc_sdram_bridge.
//                Inputs change and outputs are sampled 1 time unit after
//                each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_picosoc_sdram_bridge;

    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid;
    logic [3:0]        wen;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic [ADDR_W-1:0] az_addr;
    logic [3:0]        az_be_n;
    logic              az_cs;
    logic [31:0]       az_data;
    logic              az_rd_n;
    logic              az_wr_n;
    logic [31:0]       za_data;
    logic              za_valid;
    logic              za_waitrequest;
`ifdef PICOSOC_SDRAM_TIMEOUT_EN
    logic              timeout_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    picosoc_sdram_bridge #(
        .ADDR_W         (ADDR_W)
`ifdef PICOSOC_SDRAM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .wen            (wen),
        .addr           (addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .ready          (ready),
        .az_addr        (az_addr),
        .az_be_n        (az_be_n),
        .az_cs          (az_cs),
        .az_data        (az_data),
        .az_rd_n        (az_rd_n),
        .az_wr_n        (az_wr_n),
        .za_data        (za_data),
        .za_valid       (za_valid),
        .za_waitrequest (za_waitrequest)
`ifdef PICOSOC_SDRAM_TIMEOUT_EN
        ,
        .timeout_err    (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        valid          = 1'b0;
        wen            = 4'h0;
        addr           = '0;
        wdata          = 32'h0;
        za_data        = 32'h0;
        za_valid       = 1'b0;
        za_waitrequest = 1'b0;

        // ---------------- reset ----------------
        repeat (3) tick();
        reset = 1'b0;
        check_value("rst_ready",   ready,   0);
        check_value("rst_rd_n",    az_rd_n, 1);
        check_value("rst_wr_n",    az_wr_n, 1);
        check_value("rst_cs",      az_cs,   0);
        check_value("rst_be_n",    az_be_n, 4'hF);
        check_value("rst_rdata",   rdata,   0);
        check_value("rst_az_addr", az_addr, 0);
        tick();
        check_value("idle_ready",  ready,   0);

        // ---------------- full-word write, no stall ----------------
        valid = 1'b1; wen = 4'hF; addr = 24'h000010; wdata = 32'h12345678;
        tick();                                   // edge 0
        check_value("wr_wr_n",    az_wr_n, 0);
        check_value("wr_rd_n",    az_rd_n, 1);
        check_value("wr_cs",      az_cs,   1);
        check_value("wr_be_n",    az_be_n, 4'h0);
        check_value("wr_addr",    az_addr, 24'h000010);
        check_value("wr_data",    az_data, 32'h12345678);
        check_value("wr_rdy_c1",  ready,   0);
        tick();                                   // edge 1: accepted
        check_value("wr_rdy_c2",  ready,   1);
        check_value("wr_wr_n_c2", az_wr_n, 1);
        check_value("wr_cs_c2",   az_cs,   0);
        tick();                                   // valid still high: no relaunch
        check_value("wr_rdy_c3",  ready,   0);
        check_value("wr_norelaunch_cs", az_cs, 0);
        check_value("wr_norelaunch_wr", az_wr_n, 1);
        valid = 1'b0; wen = 4'h0;
        tick();
        check_value("wr_idle_cs", az_cs, 0);

        // ---------------- byte write, 3-cycle stall ----------------
        valid = 1'b1; wen = 4'b0100; addr = 24'h000055; wdata = 32'hA5A5A5A5;
        za_waitrequest = 1'b1;
        tick();                                   // edge 0
        check_value("bw_be_n",    az_be_n, 4'b1011);
        check_value("bw_wr_n",    az_wr_n, 0);
        valid = 1'b0;                             // dropping valid mid-transaction is ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("bw_stall_wr_n", az_wr_n, 0);
            check_value("bw_stall_be_n", az_be_n, 4'b1011);
            check_value("bw_stall_addr", az_addr, 24'h000055);
            check_value("bw_stall_data", az_data, 32'hA5A5A5A5);
            check_value("bw_stall_rdy",  ready,   0);
        end
        za_waitrequest = 1'b0;
        tick();
        check_value("bw_ready",   ready,   1);
        check_value("bw_rdata",   rdata,   0);
        check_value("bw_wr_n_x",  az_wr_n, 1);
        wen = 4'h0;
        tick();
        check_value("bw_rdy_off", ready,   0);

        // ---------------- read, data 2 cycles after acceptance ----------------
        valid = 1'b1; wen = 4'h0; addr = 24'h000020;
        za_data = 32'h11111111; za_valid = 1'b1;  // ignored outside RD_WAIT
        tick();                                   // edge 0
        check_value("rd_rd_n",    az_rd_n, 0);
        check_value("rd_wr_n",    az_wr_n, 1);
        check_value("rd_be_n",    az_be_n, 4'h0);
        check_value("rd_addr",    az_addr, 24'h000020);
        check_value("rd_cs",      az_cs,   1);
        za_valid = 1'b0;
        tick();                                   // edge 1: accepted
        check_value("rd_rd_n_x",  az_rd_n, 1);
        check_value("rd_rdy_c2",  ready,   0);
        tick();                                   // edge 2: no data yet
        check_value("rd_rdy_c3",  ready,   0);
        za_valid = 1'b1; za_data = 32'hCAFEF00D;
        tick();
        check_value("rd_ready",   ready,   1);
        check_value("rd_rdata",   rdata,   32'hCAFEF00D);
        valid = 1'b0; za_valid = 1'b0; za_data = 32'h0;
        tick();
        check_value("rd_rdy_off", ready,   0);
        check_value("rd_hold",    rdata,   32'hCAFEF00D);

        // ---------------- reset during RD_WAIT ----------------
        valid = 1'b1; wen = 4'h0; addr = 24'h000033;
        tick();                                   // RD_CMD
        tick();                                   // RD_WAIT
        valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_value("mr_rd_n",  az_rd_n, 1);
        check_value("mr_cs",    az_cs,   0);
        check_value("mr_ready", ready,   0);
        check_value("mr_rdata", rdata,   0);
        check_value("mr_addr",  az_addr, 0);
        za_valid = 1'b1; za_data = 32'h99999999;
        tick();
        check_value("mr_late_rdy1", ready, 0);
        tick();
        check_value("mr_late_rdy2", ready, 0);
        check_value("mr_late_rdata", rdata, 0);
        za_valid = 1'b0; za_data = 32'h0;
        tick();

`ifdef PICOSOC_SDRAM_TIMEOUT_EN
        // ---------------- read watchdog (TIMEOUT_CYCLES = 8) ----------------
        check_value("to_err_init", timeout_err, 0);
        valid = 1'b1; wen = 4'h0; addr = 24'h000044;
        tick();                                   // edge 0: RD_CMD
        tick();                                   // edge 1: RD_WAIT entered
        valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_value("to_wait_rdy", ready, 0);
        end
        tick();                                   // 8th RD_WAIT cycle ends
        check_value("to_ready", ready,       1);
        check_value("to_rdata", rdata,       32'hDEADBEEF);
        check_value("to_err",   timeout_err, 1);
        tick();
        check_value("to_rdy_off",  ready,       0);
        check_value("to_err_stky", timeout_err, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run can never hang
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, got no finish, want finish");
        $fatal(1, "time limit");
    end

endmodule : tb_picosoc_sdram_bridge
`default_nettype wire
